i2c_slave_regs: RTL and testbench

I2C target (slave) with an 8-byte register file, the responder counterpart to the team's I2C master core. An external I2C master reads and writes the registers over SCL/SDA using a pointer-byte protocol. The system CPU reaches the same registers through a Wishbone-style local port.

---
 rtl/i2c_slave_regs.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target with an 8-byte register file that is shared with
// a Wishbone-style local port. An I2C write's first data byte selects the
// register pointer; later bytes are written (or read) with auto-increment.
// Optional feature macro: I2C_SLAVE_IRQ_EN enables the end-of-write interrupt
// flag on wb_inta_o. Without it wb_inta_o is tied low.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  output logic       wb_ack_o,
  output logic       wb_inta_o,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR,
    S_WR_ACK,
    S_RD,
    S_RD_ACK
  } state_t;

  // Synchronizer and delay stages for the bus lines.
  logic scl_meta, scl_sync, scl_dly;
  logic sda_meta, sda_sync, sda_dly;

  // Decoded bus events.
  logic scl_rise, scl_fall, start_cond, stop_cond;

  // Protocol state.
  state_t     state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic       rw, rw_nxt;
  logic       ack_phase, ack_phase_nxt;
  logic       oen, oen_nxt;

  // Register file and write controls.
  logic [7:0] regs [8];
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       i2c_we;
  logic       wb_req;
  logic       wb_wr;

  // Two-flop synchronizers followed by a delay stage; idle bus level is high.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_dly  <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_dly  <= 1'b1;
    end else begin
      scl_meta <= scl_pad_i;
      scl_sync <= scl_meta;
      scl_dly  <= scl_sync;
      sda_meta <= sda_pad_i;
      sda_sync <= sda_meta;
      sda_dly  <= sda_sync;
    end
  end

  assign scl_rise   = scl_sync & ~scl_dly;
  assign scl_fall   = ~scl_sync & scl_dly;
  assign start_cond = scl_sync & scl_dly & sda_dly & ~sda_sync;
  assign stop_cond  = scl_sync & scl_dly & ~sda_dly & sda_sync;

  assign rx_byte = {shift[6:0], sda_sync};
  assign rd_byte = regs[ptr];

  assign wb_req = wb_stb_i & ~wb_ack_o;
  assign wb_wr  = wb_req & wb_we_i;

  // Protocol state register; releasing SDA on reset is asynchronous.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      ptr       <= 3'd0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      oen       <= 1'b1;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      ptr       <= ptr_nxt;
      rw        <= rw_nxt;
      ack_phase <= ack_phase_nxt;
      oen       <= oen_nxt;
    end
  end

  // Next-state logic: START/STOP override everything, otherwise per-state bit handling.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    ptr_nxt       = ptr;
    rw_nxt        = rw;
    ack_phase_nxt = ack_phase;
    oen_nxt       = oen;
    i2c_we        = 1'b0;

    if (start_cond) begin
      state_nxt     = S_ADDR;
      bit_cnt_nxt   = 4'd0;
      ack_phase_nxt = 1'b0;
      oen_nxt       = 1'b1;
    end else if (stop_cond) begin
      state_nxt     = S_IDLE;
      bit_cnt_nxt   = 4'd0;
      ack_phase_nxt = 1'b0;
      oen_nxt       = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          oen_nxt = 1'b1;
        end

        S_ADDR: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_nxt     = S_ADDR_ACK;
                rw_nxt        = rx_byte[0];
                ack_phase_nxt = 1'b0;
              end else begin
                state_nxt = S_IDLE;
              end
            end
          end
        end

        S_PTR: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ptr_nxt       = rx_byte[2:0];
              state_nxt     = S_PTR_ACK;
              ack_phase_nxt = 1'b0;
            end
          end
        end

        S_WR: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              i2c_we        = 1'b1;
              ptr_nxt       = ptr + 3'd1;
              state_nxt     = S_WR_ACK;
              ack_phase_nxt = 1'b0;
            end
          end
        end

        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              oen_nxt       = 1'b0;
              ack_phase_nxt = 1'b1;
            end else begin
              ack_phase_nxt = 1'b0;
              bit_cnt_nxt   = 4'd0;
              if (state == S_ADDR_ACK && rw) begin
                shift_nxt   = rd_byte;
                oen_nxt     = rd_byte[7];
                bit_cnt_nxt = 4'd1;
                state_nxt   = S_RD;
              end else begin
                oen_nxt   = 1'b1;
                state_nxt = (state == S_ADDR_ACK) ? S_PTR : S_WR;
              end
            end
          end
        end

        S_RD: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              oen_nxt       = 1'b1;
              ack_phase_nxt = 1'b0;
              state_nxt     = S_RD_ACK;
            end else begin
              shift_nxt   = {shift[6:0], 1'b0};
              oen_nxt     = shift[6];
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end

        S_RD_ACK: begin
          if (!ack_phase) begin
            if (scl_rise) begin
              if (!sda_sync) begin
                ptr_nxt       = ptr + 3'd1;
                ack_phase_nxt = 1'b1;
              end else begin
                state_nxt = S_IDLE;
              end
            end
          end else if (scl_fall) begin
            shift_nxt     = rd_byte;
            oen_nxt       = rd_byte[7];
            bit_cnt_nxt   = 4'd1;
            ack_phase_nxt = 1'b0;
            state_nxt     = S_RD;
          end
        end

        default: begin
          state_nxt = S_IDLE;
          oen_nxt   = 1'b1;
        end
      endcase
    end
  end

  // Register file: an I2C write to the same index beats a local write.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (i2c_we && ptr == 3'(i)) begin
          regs[i] <= rx_byte;
        end else if (wb_wr && wb_adr_i == 3'(i)) begin
          regs[i] <= wb_dat_i;
        end
      end
    end
  end

  // Local port: one-cycle ack, read data captured alongside the ack.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
    end else begin
      wb_ack_o <= wb_req;
      if (wb_req && !wb_we_i) begin
        wb_dat_o <= regs[wb_adr_i];
      end
    end
  end

`ifdef I2C_SLAVE_IRQ_EN
  logic stored;
  logic irq;
  logic irq_set;

  assign irq_set = (start_cond | stop_cond) & stored;

  // Remember whether the current transfer stored any data byte.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      stored <= 1'b0;
    end else if (start_cond || stop_cond) begin
      stored <= 1'b0;
    end else if (i2c_we) begin
      stored <= 1'b1;
    end
  end

  // Interrupt flag: set at the end of a storing write, cleared by any local ack.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (wb_req) begin
      irq <= 1'b0;
    end
  end

  assign wb_inta_o = irq;
`else
  assign wb_inta_o = 1'b0;
`endif

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master plus local port
// tasks, checking against hand-computed register and bus values.
module tb_i2c_slave_regs;

  localparam int Q = 5;

`ifdef I2C_SLAVE_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst_n;
  logic [2:0] wb_adr;
  logic [7:0] wb_wdat;
  logic [7:0] wb_rdat;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;
  logic       wb_inta;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_out;
  logic       sda_oen;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic       ack_bit;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  assign sda_line = sda_m & (sda_oen | sda_out);

  i2c_slave_regs #(.SLAVE_ADDR(7'h42)) dut (
    .wb_clk_i     (clk),
    .arst_i       (arst_n),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_wdat),
    .wb_dat_o     (wb_rdat),
    .wb_we_i      (wb_we),
    .wb_stb_i     (wb_stb),
    .wb_ack_o     (wb_ack),
    .wb_inta_o    (wb_inta),
    .scl_pad_i    (scl_m),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_out),
    .sda_padoen_o (sda_oen)
  );

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    b = sda_line;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack);
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [7:0] d);
    wb_adr  = adr;
    wb_wdat = d;
    wb_we   = 1'b1;
    wb_stb  = 1'b1;
    @(negedge clk);
    checkOutput("wb_write_ack", 8'(wb_ack), 8'h01);
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_read(input logic [2:0] adr, output logic [7:0] d);
    wb_adr = adr;
    wb_we  = 1'b0;
    wb_stb = 1'b1;
    @(negedge clk);
    checkOutput("wb_read_ack", 8'(wb_ack), 8'h01);
    d = wb_rdat;
    wb_stb = 1'b0;
    @(negedge clk);
  endtask

  // Full I2C write transaction: address 0x42/W, pointer byte, two data bytes, STOP.
  task automatic applyStimulus(input logic [7:0] ptr_byte, input logic [7:0] d0, input logic [7:0] d1);
    logic a;
    i2c_start();
    write_byte(8'h84, a);
    checkOutput("wr_addr_ack", 8'(a), 8'h00);
    write_byte(ptr_byte, a);
    checkOutput("wr_ptr_ack", 8'(a), 8'h00);
    write_byte(d0, a);
    checkOutput("wr_d0_ack", 8'(a), 8'h00);
    write_byte(d1, a);
    checkOutput("wr_d1_ack", 8'(a), 8'h00);
    i2c_stop();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    arst_n  = 1'b0;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    wb_adr  = 3'd0;
    wb_wdat = 8'h00;
    wb_we   = 1'b0;
    wb_stb  = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_ack", 8'(wb_ack), 8'h00);
    checkOutput("rst_dat", wb_rdat, 8'h00);
    checkOutput("rst_inta", 8'(wb_inta), 8'h00);
    checkOutput("rst_oen", 8'(sda_oen), 8'h01);
    checkOutput("rst_sda_o", 8'(sda_out), 8'h00);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic write: pointer 2, reg2=AA, reg3=BB.
    applyStimulus(8'h02, 8'hAA, 8'hBB);
    checkOutput("t1_inta_after_stop", 8'(wb_inta), 8'(IRQ_EXP));
    wb_read(3'd2, rdata);
    checkOutput("t1_reg2", rdata, 8'hAA);
    checkOutput("t1_inta_after_ack", 8'(wb_inta), 8'h00);
    wb_read(3'd3, rdata);
    checkOutput("t1_reg3", rdata, 8'hBB);

    // Read with repeated START: reg5 then reg6.
    wb_write(3'd5, 8'h5A);
    i2c_start();
    write_byte(8'h84, ack_bit);
    checkOutput("t2_addr_w_ack", 8'(ack_bit), 8'h00);
    write_byte(8'h05, ack_bit);
    checkOutput("t2_ptr_ack", 8'(ack_bit), 8'h00);
    i2c_start();
    write_byte(8'h85, ack_bit);
    checkOutput("t2_addr_r_ack", 8'(ack_bit), 8'h00);
    read_byte(1'b0, rdata);
    checkOutput("t2_rd0", rdata, 8'h5A);
    read_byte(1'b1, rdata);
    checkOutput("t2_rd1", rdata, 8'h00);
    checkOutput("t2_oen_after_nack", 8'(sda_oen), 8'h01);
    i2c_stop();
    checkOutput("t2_inta_read_only", 8'(wb_inta), 8'h00);

    // Pointer wrap 7 -> 0.
    applyStimulus(8'h07, 8'h11, 8'h22);
    wb_read(3'd7, rdata);
    checkOutput("t3_reg7", rdata, 8'h11);
    wb_read(3'd0, rdata);
    checkOutput("t3_reg0", rdata, 8'h22);

    // Address mismatch: no ACK, nothing changes.
    i2c_start();
    write_byte(8'h86, ack_bit);
    checkOutput("t4_nack", 8'(ack_bit), 8'h01);
    i2c_stop();
    checkOutput("t4_inta", 8'(wb_inta), 8'h00);
    wb_read(3'd0, rdata);
    checkOutput("t4_reg0", rdata, 8'h22);

    // Collision on reg1: I2C 0x33 commits in the same cycle as local 0x44.
    i2c_start();
    write_byte(8'h84, ack_bit);
    checkOutput("t5_addr_ack", 8'(ack_bit), 8'h00);
    write_byte(8'h01, ack_bit);
    checkOutput("t5_ptr_ack", 8'(ack_bit), 8'h00);
    for (int i = 7; i >= 1; i--) send_bit(((8'h33 >> i) & 8'h01) != 8'h00);
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wb_adr  = 3'd1;
    wb_wdat = 8'h44;
    wb_we   = 1'b1;
    wb_stb  = 1'b1;
    @(negedge clk);
    checkOutput("t5_local_ack", 8'(wb_ack), 8'h01);
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    repeat (2 * Q - 3) @(negedge clk);
    scl_m = 1'b0;
    wait_q();
    recv_bit(ack_bit);
    checkOutput("t5_data_ack", 8'(ack_bit), 8'h00);
    i2c_stop();
    wb_read(3'd1, rdata);
    checkOutput("t5_reg1", rdata, 8'h33);

    // Reset asserted while the slave drives the address ACK of a read.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h85 >> i) & 8'h01) != 8'h00);
    sda_m = 1'b1;
    wait_q();
    checkOutput("t6_ack_driven", 8'(sda_oen), 8'h00);
    #1 arst_n = 1'b0;
    #1 checkOutput("t6_oen_async", 8'(sda_oen), 8'h01);
    @(negedge clk);
    arst_n = 1'b1;
    scl_m = 1'b1;
    wait_q();
    scl_m = 1'b0;
    wait_q();
    i2c_stop();

    // Fresh transaction after reset; registers were cleared by the reset.
    applyStimulus(8'h03, 8'h77, 8'h88);
    wb_read(3'd3, rdata);
    checkOutput("t6_reg3", rdata, 8'h77);
    wb_read(3'd4, rdata);
    checkOutput("t6_reg4", rdata, 8'h88);
    wb_read(3'd5, rdata);
    checkOutput("t6_reg5_cleared", rdata, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
